// File: rtl/axi_resp_pkg.sv
// Shared types and constants for the AXI memory responder.
// Response codes, beat size and FSM state encodings.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_64B    = 3'b110;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// 512-bit AXI4-style memory port between an app master
// and the memory responder.
interface axi_mem_responder_if;

  logic [15:0]  arid_s;
  logic [63:0]  araddr_s;
  logic [7:0]   arlen_s;
  logic [2:0]   arsize_s;
  logic         arvalid_s;
  logic         arready_s;

  logic [15:0]  rid_s;
  logic [511:0] rdata_s;
  logic [1:0]   rresp_s;
  logic         rlast_s;
  logic         rvalid_s;
  logic         rready_s;

  logic [15:0]  awid_s;
  logic [63:0]  awaddr_s;
  logic [7:0]   awlen_s;
  logic [2:0]   awsize_s;
  logic         awvalid_s;
  logic         awready_s;

  logic [15:0]  wid_s;
  logic [511:0] wdata_s;
  logic [63:0]  wstrb_s;
  logic         wlast_s;
  logic         wvalid_s;
  logic         wready_s;

  logic [15:0]  bid_s;
  logic [1:0]   bresp_s;
  logic         bvalid_s;
  logic         bready_s;

  modport master (
    output arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
    input  arready_s,
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    output rready_s,
    output awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
    input  awready_s,
    output wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s,
    input  wready_s,
    input  bid_s, bresp_s, bvalid_s,
    output bready_s
  );

  modport slave (
    input  arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
    output arready_s,
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    input  rready_s,
    input  awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
    output awready_s,
    input  wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s,
    output wready_s,
    output bid_s, bresp_s, bvalid_s,
    input  bready_s
  );

endinterface

// File: rtl/axi_mem_bank.sv
// Dual-port line RAM: synchronous read, byte-enabled write,
// read-before-write when both ports hit the same line.
module axi_mem_bank #(
  parameter int LOG_DEPTH = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rd_en,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output logic [511:0]         rd_data,
  input  logic                 wr_en,
  input  logic [LOG_DEPTH-1:0] wr_addr,
  input  logic [511:0]         wr_data,
  input  logic [63:0]          wr_strb
);

  logic [511:0] mem [2**LOG_DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 64; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Output only moves on rd_en so a stalled beat stays put.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-style 512-bit memory responder backed by a line array;
// one read and one write burst in flight concurrently.
module axi_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int LOG_DEPTH = 10,
  parameter int MAX_BEATS = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  axi_mem_responder_if.slave  s,
  output logic [31:0]         rd_beats,
  output logic [31:0]         wr_beats
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef logic [CW-1:0]        cnt_t;
  typedef logic [LOG_DEPTH-1:0] idx_t;

  function automatic logic len_over(input logic [7:0] len);
    return int'(len) >= MAX_BEATS;
  endfunction

  function automatic cnt_t clip_len(input logic [7:0] len);
    if (len_over(len)) return cnt_t'(MAX_BEATS - 1);
    return cnt_t'(len);
  endfunction

  r_state_t r_state;
  idx_t     r_idx;
  cnt_t     r_cnt;
  cnt_t     r_num;
  logic     r_hs;
  logic     rd_en;
  idx_t     rd_addr;

  w_state_t w_state;
  idx_t     w_idx;
  cnt_t     w_cnt;
  cnt_t     w_num;
  logic     w_err;
  logic     w_done;
  logic     w_hs;
  logic     wr_en;

  logic     unused;

  assign unused = ^{s.wid_s,
                    s.araddr_s[63:LOG_DEPTH+6], s.araddr_s[5:0],
                    s.awaddr_s[63:LOG_DEPTH+6], s.awaddr_s[5:0]};

  assign r_hs    = s.rvalid_s && s.rready_s;
  assign rd_en   = (r_state == R_FETCH) || (r_hs && !s.rlast_s);
  assign rd_addr = r_hs ? r_idx + idx_t'(1) : r_idx;

  assign w_hs  = s.wvalid_s && s.wready_s;
  assign wr_en = w_hs && !w_done;

  axi_mem_bank #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (s.rdata_s),
    .wr_en   (wr_en),
    .wr_addr (w_idx),
    .wr_data (s.wdata_s),
    .wr_strb (s.wstrb_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= R_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_num       <= '0;
      s.arready_s <= 1'b0;
      s.rvalid_s  <= 1'b0;
      s.rlast_s   <= 1'b0;
      s.rid_s     <= '0;
      s.rresp_s   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s.arready_s <= 1'b1;
          if (s.arvalid_s && s.arready_s) begin
            s.arready_s <= 1'b0;
            s.rid_s     <= s.arid_s;
            r_idx       <= s.araddr_s[LOG_DEPTH+5:6];
            r_num       <= clip_len(s.arlen_s);
            r_cnt       <= '0;
            s.rresp_s   <= (s.arsize_s != SIZE_64B || len_over(s.arlen_s))
                           ? RESP_SLVERR : RESP_OKAY;
            r_state     <= R_FETCH;
          end
        end
        R_FETCH: begin
          s.rvalid_s <= 1'b1;
          s.rlast_s  <= (r_num == '0);
          r_state    <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            if (s.rlast_s) begin
              s.rvalid_s  <= 1'b0;
              s.rlast_s   <= 1'b0;
              s.arready_s <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_cnt     <= r_cnt + cnt_t'(1);
              r_idx     <= r_idx + idx_t'(1);
              s.rlast_s <= (r_cnt + cnt_t'(1) == r_num);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state     <= W_IDLE;
      w_idx       <= '0;
      w_cnt       <= '0;
      w_num       <= '0;
      w_err       <= 1'b0;
      w_done      <= 1'b0;
      s.awready_s <= 1'b0;
      s.wready_s  <= 1'b0;
      s.bvalid_s  <= 1'b0;
      s.bid_s     <= '0;
      s.bresp_s   <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s.awready_s <= 1'b1;
          if (s.awvalid_s && s.awready_s) begin
            s.awready_s <= 1'b0;
            s.wready_s  <= 1'b1;
            s.bid_s     <= s.awid_s;
            w_idx       <= s.awaddr_s[LOG_DEPTH+5:6];
            w_num       <= clip_len(s.awlen_s);
            w_cnt       <= '0;
            w_done      <= 1'b0;
            w_err       <= (s.awsize_s != SIZE_64B) || len_over(s.awlen_s);
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx <= w_idx + idx_t'(1);
            // w_done marks that the expected count is used up.
            if (s.wlast_s) begin
              s.wready_s <= 1'b0;
              s.bvalid_s <= 1'b1;
              s.bresp_s  <= (w_err || w_done || w_cnt != w_num)
                            ? RESP_SLVERR : RESP_OKAY;
              w_state    <= W_RESP;
            end else if (w_done) begin
              w_err <= 1'b1;
            end else if (w_cnt == w_num) begin
              w_done <= 1'b1;
            end else begin
              w_cnt <= w_cnt + cnt_t'(1);
            end
          end
        end
        W_RESP: begin
          if (s.bvalid_s && s.bready_s) begin
            s.bvalid_s  <= 1'b0;
            s.awready_s <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else begin
      if (r_hs) rd_beats <= rd_beats + 32'd1;
      if (w_hs) wr_beats <= wr_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a read scoreboard
// and a line-array reference model.
module tb_axi_mem_responder;

  typedef struct {
    logic [511:0] d;
    logic [1:0]   resp;
    logic         last;
    logic [15:0]  id;
  } rexp_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;

  int checks = 0;
  int errors = 0;

  logic [511:0] mem_m [16];
  rexp_t        q [$];

  axi_mem_responder_if bus ();

  axi_mem_responder #(
    .LOG_DEPTH (4),
    .MAX_BEATS (64)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .s        (bus),
    .rd_beats (rd_beats),
    .wr_beats (wr_beats)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [7:0] sd, input int b);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = {sd, 8'(b), 8'(i), 8'h5A};
    if (sd == 8'hAA) p = {64{8'hAA}};
    return p;
  endfunction

  task automatic wr_burst(input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [15:0] id,
                          input int nb, input logic [63:0] strb,
                          input logic [7:0] sd, input logic [1:0] exp_resp,
                          input bit hold_b);
    int n;
    int idx;
    int k;
    logic [511:0] d;
    n   = (int'(len) >= 64) ? 64 : int'(len) + 1;
    idx = int'(addr[9:6]);
    bus.bready_s  = !hold_b;
    bus.awid_s    = id;
    bus.awaddr_s  = addr;
    bus.awlen_s   = len;
    bus.awsize_s  = size;
    bus.awvalid_s = 1'b1;
    k = 0;
    while (!bus.awready_s && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("aw_timeout", 512'(k < 50), 512'(1));
    @(negedge clock);
    bus.awvalid_s = 1'b0;
    for (int b = 0; b < nb; b++) begin
      d = pat(sd, b);
      bus.wdata_s  = d;
      bus.wstrb_s  = strb;
      bus.wlast_s  = (b == nb - 1);
      bus.wvalid_s = 1'b1;
      k = 0;
      while (!bus.wready_s && k < 50) begin
        @(negedge clock);
        k++;
      end
      if (k >= 50) chk("w_timeout", 512'(k), 512'(0));
      if (b < n) begin
        for (int i = 0; i < 64; i++)
          if (strb[i]) mem_m[(idx + b) % 16][8*i +: 8] = d[8*i +: 8];
      end
      @(negedge clock);
    end
    bus.wvalid_s = 1'b0;
    bus.wlast_s  = 1'b0;
    k = 0;
    while (!bus.bvalid_s && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("b_timeout", 512'(k < 50), 512'(1));
    chk("bresp", 512'(bus.bresp_s), 512'(exp_resp));
    chk("bid", 512'(bus.bid_s), 512'(id));
    if (!hold_b) begin
      @(negedge clock);
      chk("b_drop", 512'(bus.bvalid_s), 512'(0));
    end
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [15:0] id,
                          input bit toggle, input int stop_after);
    int n;
    int idx;
    int k;
    int got;
    int cyc;
    logic [1:0] er;
    logic [511:0] held;
    bit stalled;
    rexp_t e;
    n   = (int'(len) >= 64) ? 64 : int'(len) + 1;
    er  = (size != 3'b110 || int'(len) >= 64) ? 2'b10 : 2'b00;
    idx = int'(addr[9:6]);
    for (int b = 0; b < n; b++) begin
      e.d    = mem_m[(idx + b) % 16];
      e.resp = er;
      e.last = (b == n - 1);
      e.id   = id;
      q.push_back(e);
    end
    bus.rready_s  = 1'b0;
    bus.arid_s    = id;
    bus.araddr_s  = addr;
    bus.arlen_s   = len;
    bus.arsize_s  = size;
    bus.arvalid_s = 1'b1;
    k = 0;
    while (!bus.arready_s && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("ar_timeout", 512'(k < 50), 512'(1));
    @(negedge clock);
    bus.arvalid_s = 1'b0;
    chk("r_latency_t1", 512'(bus.rvalid_s), 512'(0));
    @(negedge clock);
    chk("r_latency_t2", 512'(bus.rvalid_s), 512'(1));
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (got < stop_after && cyc < 500) begin
      if (stalled) chk("r_hold", bus.rdata_s, held);
      bus.rready_s = toggle ? cyc[0] : 1'b1;
      stalled = bus.rvalid_s && !bus.rready_s;
      held = bus.rdata_s;
      if (bus.rvalid_s && bus.rready_s) begin
        e = q.pop_front();
        chk("rdata", bus.rdata_s, e.d);
        chk("rresp", 512'(bus.rresp_s), 512'(e.resp));
        chk("rlast", 512'(bus.rlast_s), 512'(e.last));
        chk("rid", 512'(bus.rid_s), 512'(e.id));
        got++;
      end
      @(negedge clock);
      cyc++;
    end
    bus.rready_s = 1'b0;
    chk("r_beats_seen", 512'(got), 512'(stop_after));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.arid_s    = '0;
    bus.araddr_s  = '0;
    bus.arlen_s   = '0;
    bus.arsize_s  = 3'b110;
    bus.arvalid_s = 1'b0;
    bus.rready_s  = 1'b0;
    bus.awid_s    = '0;
    bus.awaddr_s  = '0;
    bus.awlen_s   = '0;
    bus.awsize_s  = 3'b110;
    bus.awvalid_s = 1'b0;
    bus.wid_s     = '0;
    bus.wdata_s   = '0;
    bus.wstrb_s   = '0;
    bus.wlast_s   = 1'b0;
    bus.wvalid_s  = 1'b0;
    bus.bready_s  = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_arready", 512'(bus.arready_s), 512'(0));
    chk("rst_awready", 512'(bus.awready_s), 512'(0));
    chk("rst_rvalid", 512'(bus.rvalid_s), 512'(0));
    chk("rst_bvalid", 512'(bus.bvalid_s), 512'(0));
    chk("rst_rdata", bus.rdata_s, 512'(0));
    chk("rst_rid", 512'(bus.rid_s), 512'(0));
    chk("rst_bid", 512'(bus.bid_s), 512'(0));
    chk("rst_rd_beats", 512'(rd_beats), 512'(0));
    chk("rst_wr_beats", 512'(wr_beats), 512'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_arready", 512'(bus.arready_s), 512'(1));
    chk("idle_awready", 512'(bus.awready_s), 512'(1));
    chk("idle_wready", 512'(bus.wready_s), 512'(0));

    // Basic 4-beat write then read at 0x1000.
    wr_burst(64'h1000, 8'd3, 3'b110, 16'h0011, 4, '1, 8'h01, 2'b00, 1'b0);
    chk("wr_beats_4", 512'(wr_beats), 512'(4));
    rd_burst(64'h1000, 8'd3, 3'b110, 16'h0022, 1'b0, 4);
    chk("rd_beats_4", 512'(rd_beats), 512'(4));

    // Burst wrapping past the last line.
    wr_burst(64'd14 * 64, 8'd3, 3'b110, 16'h0033, 4, '1, 8'h02, 2'b00, 1'b0);
    rd_burst(64'h0, 8'd0, 3'b110, 16'h0034, 1'b0, 1);
    chk("wrap_line0", mem_m[0], pat(8'h02, 2));
    rd_burst(64'd14 * 64, 8'd3, 3'b110, 16'h0035, 1'b0, 4);

    // Partial strobe over a 0xAA line.
    wr_burst(64'd5 * 64, 8'd0, 3'b110, 16'h0041, 1, '1, 8'hAA, 2'b00, 1'b0);
    wr_burst(64'd5 * 64, 8'd0, 3'b110, 16'h0042, 1, 64'hFF, 8'h03, 2'b00, 1'b0);
    rd_burst(64'd5 * 64, 8'd0, 3'b110, 16'h0043, 1'b0, 1);

    // Protocol errors.
    wr_burst(64'd7 * 64, 8'd1, 3'b110, 16'h0051, 1, '1, 8'h04, 2'b10, 1'b0);
    rd_burst(64'd14 * 64, 8'd1, 3'b101, 16'h0052, 1'b0, 2);
    wr_burst(64'h0, 8'd99, 3'b110, 16'h0053, 64, '1, 8'h05, 2'b10, 1'b0);
    rd_burst(64'h0, 8'd99, 3'b110, 16'h0054, 1'b0, 64);

    // Reset with a write parked in response and a read mid-burst.
    wr_burst(64'd3 * 64, 8'd3, 3'b110, 16'h0061, 4, '1, 8'h06, 2'b00, 1'b1);
    rd_burst(64'd8 * 64, 8'd7, 3'b110, 16'h0062, 1'b0, 3);
    chk("pre_rst_rvalid", 512'(bus.rvalid_s), 512'(1));
    chk("pre_rst_bvalid", 512'(bus.bvalid_s), 512'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 512'(bus.rvalid_s), 512'(0));
    chk("mid_rst_bvalid", 512'(bus.bvalid_s), 512'(0));
    chk("mid_rst_arready", 512'(bus.arready_s), 512'(0));
    chk("mid_rst_rd_beats", 512'(rd_beats), 512'(0));
    chk("mid_rst_wr_beats", 512'(wr_beats), 512'(0));
    q.delete();
    bus.bready_s = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_arready", 512'(bus.arready_s), 512'(1));
    chk("post_rst_awready", 512'(bus.awready_s), 512'(1));
    chk("post_rst_rvalid", 512'(bus.rvalid_s), 512'(0));
    chk("post_rst_bvalid", 512'(bus.bvalid_s), 512'(0));
    chk("post_rst_rd_beats", 512'(rd_beats), 512'(0));
    chk("post_rst_wr_beats", 512'(wr_beats), 512'(0));

    // Back-pressured 16-beat read.
    rd_burst(64'h0, 8'd15, 3'b110, 16'h0071, 1'b1, 16);
    chk("bp_rd_beats", 512'(rd_beats), 512'(16));
    chk("bp_queue_empty", 512'(q.size()), 512'(0));
    wr_burst(64'd9 * 64, 8'd1, 3'b110, 16'h0072, 2, '1, 8'h07, 2'b00, 1'b0);
    chk("final_wr_beats", 512'(wr_beats), 512'(2));
    rd_burst(64'd9 * 64, 8'd1, 3'b110, 16'h0073, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4-style 512-bit subordinate (responder) that terminates the memory-master ports driven by app blocks such as the AES stream engine.
- Backs reads and writes with an internal line-addressed array of 64-byte lines.
- Used in simulation and on-fabric loopback so app masters can be exercised without DDR.
- Serves one read burst and one write burst concurrently; each channel has at most one burst in flight.

Parameters:
- LOG_DEPTH, 10, log2 of the number of 512-bit lines in the backing array.
- MAX_BEATS, 64, maximum burst length accepted; any larger len is clipped and flagged SLVERR.

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- arid_s  in  16  read ID
- araddr_s  in  64  read byte address
- arlen_s  in  8  beats-1
- arsize_s  in  3  must be 3'b110
- arvalid_s  in  1  AR valid
- arready_s  out  1  AR ready
- rid_s  out  16  echoed arid
- rdata_s  out  512  read data
- rresp_s  out  2  00 OKAY / 10 SLVERR
- rlast_s  out  1  final beat
- rvalid_s  out  1  R valid
- rready_s  in  1  R ready
- awid_s  in  16  write ID
- awaddr_s  in  64  write byte address
- awlen_s  in  8  beats-1
- awsize_s  in  3  must be 3'b110
- awvalid_s  in  1  AW valid
- awready_s  out  1  AW ready
- wid_s  in  16  ignored
- wdata_s  in  512  write data
- wstrb_s  in  64  byte enables
- wlast_s  in  1  final beat
- wvalid_s  in  1  W valid
- wready_s  out  1  W ready
- bid_s  out  16  echoed awid
- bresp_s  out  2  write response
- bvalid_s  out  1  B valid
- bready_s  in  1  B ready
- rd_beats  out  32  count of R handshakes, wraps mod 2^32
- wr_beats  out  32  count of W handshakes, wraps mod 2^32

Behaviour:
- Reset: reset_n low asynchronously forces both FSMs to IDLE.
  - All valids low; arready_s and awready_s low.
  - rid_s, rresp_s, bid_s, bresp_s, rdata_s, rd_beats, wr_beats all 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst; no B or remaining R beats are issued.
- Line index = addr[LOG_DEPTH+5:6].
  - addr[5:0] is ignored.
  - Upper bits are ignored; the address wraps modulo depth.
  - The index increments by 1 per beat and wraps silently at depth-1 -> 0.
- Read FSM, states R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: arready_s=1; AR handshake latches id, index, beats=arlen+1 (clipped to MAX_BEATS); go to R_FETCH.
  - R_FETCH: one cycle for the synchronous array read; rvalid_s=0.
  - Latency: AR handshake at cycle T gives rvalid_s high at T+2.
  - R_DATA: rvalid_s=1 and rdata_s holds the current line.
  - Array read address = next index when rvalid&&rready, else current index, so rready held high yields one beat per cycle.
  - rlast_s=1 on beat count-1; the handshake of that beat returns the FSM to R_IDLE.
  - arready_s is low outside R_IDLE; the next AR is accepted the cycle after return.
  - rvalid_s and rdata_s stay stable while rready_s is low.
  - rresp_s=10 on every beat if arsize_s!=6 or the len was clipped; data is still returned.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready_s=1; AW handshake latches id, index, expected beats, and the error flag (awsize!=6 or len clipped).
  - W_DATA: wready_s=1. Each W handshake writes bytes whose wstrb bit is 1, in the same cycle; then index+1 and beat counter+1.
  - Beats after the expected count are accepted but not written, and set the error flag.
  - wlast_s on the handshake moves to W_RESP. If the beat counter != expected-1 at wlast, the error flag is set.
  - W_RESP: bvalid_s=1, bresp_s = error ? 10 : 00; the bready_s handshake returns to W_IDLE.
  - wready_s is 0 outside W_DATA; W beats before AW are back-pressured.
- Read/write collision on the same line in the same cycle: read returns old data (read-before-write). The next fetch sees the new data.
- Counters increment on their respective data handshakes; simultaneous events are independent.

Decomposition:
- Shared package (axi_resp_pkg):
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, SIZE_64B=3'b110.
  - FSM state encodings for the read and write FSMs.
- One sub-module: axi_mem_bank, a dual-port RAM of 2^LOG_DEPTH x 512 bits.
  - Synchronous read port.
  - Write port with 64 byte-enables.
  - Read-before-write on collision.

Test Plan:
- Write 4 beats at awaddr 0x1000 with awlen=3 and wstrb all-ones; then read 4 beats at 0x1000 -> rdata matches; rlast only on beat 3; bresp=00 and rresp=00; rvalid first rises 2 cycles after AR handshake.
- Burst crossing depth: LOG_DEPTH=4, write 4 beats at line 14 -> lines 14, 15, 0, 1 written. Read at line 0 -> line-2 pattern.
- wstrb=0x0000_0000_0000_00FF on a line prefilled with 0xAA -> only bytes 0-7 updated; the remaining 56 bytes stay 0xAA.
- Back-pressure: rready toggles every other cycle on a 16-beat read -> exactly 16 handshakes; data held stable while stalled; rd_beats=16.
- Protocol errors:
  - awlen=1 with wlast on beat 0 -> bresp=10.
  - arsize=3'b101 -> all beats rresp=10.
  - awlen=99 -> clipped to 64 beats, SLVERR.
- Drive reset_n low mid 8-beat read (after beat 3) and mid write -> rvalid and bvalid drop immediately. After release, arready=awready=1 and counters=0.
